// File: rtl/lfsr.sv
// Fibonacci LFSR pseudo-random word generator with a lockup guard.
// Supported widths 8/16/24/32 use maximal-length taps; anything else fails elaboration.
module lfsr #(
  parameter int          WIDTH = 16,
  parameter logic [31:0] SEED  = 32'h0000_ACE1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] out
);

  function automatic logic [31:0] tap_mask(input int w);
    case (w)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      24:      return 32'h00E1_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

  if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 24 || WIDTH == 32)) begin : g_bad_width
    $error("lfsr: WIDTH must be 8, 16, 24 or 32");
  end

  localparam logic [31:0]      TAPS_ALL = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_W   = SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  // A zero seed would lock the register, so it is promoted to 1.
  localparam logic [WIDTH-1:0] EFF_SEED = (SEED_W == '0) ? ONE : SEED_W;

  logic [WIDTH-1:0] state = EFF_SEED;
  logic             fb;

  assign fb  = ^(state & TAPS);
  assign out = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EFF_SEED;
    end else if (state == '0) begin
      state <= EFF_SEED;
    end else begin
      state <= {state[WIDTH-2:0], fb};
    end
  end

endmodule

// File: tb/tb_lfsr.sv
// Directed bench for lfsr: reset/step vectors, full periods at 16 and 8 bits,
// lockup recovery, zero-seed promotion and first steps at 24/32 bits.
module tb_lfsr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] out16;
  logic [15:0] out0;
  logic [7:0]  out8;
  logic [23:0] out24;
  logic [31:0] out32;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lfsr #(.WIDTH(16))                     dut16 (.clk(clk), .rst(rst), .out(out16));
  lfsr #(.WIDTH(16), .SEED(32'h0))       dut0  (.clk(clk), .rst(rst), .out(out0));
  lfsr #(.WIDTH(8),  .SEED(32'h01))      dut8  (.clk(clk), .rst(rst), .out(out8));
  lfsr #(.WIDTH(24))                     dut24 (.clk(clk), .rst(rst), .out(out24));
  lfsr #(.WIDTH(32))                     dut32 (.clk(clk), .rst(rst), .out(out32));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r);
    rst = r;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        r;
    logic [15:0] exp16;
    logic [15:0] exp0;
  } vec_t;

  vec_t vecs[8];

  bit [255:0] seen8;
  int         early16, zero16, early8, dup8, cnt8;

  initial begin
    vecs[0] = '{1'b1, 16'hACE1, 16'h0001};
    vecs[1] = '{1'b1, 16'hACE1, 16'h0001};
    vecs[2] = '{1'b0, 16'h59C3, 16'h0002};
    vecs[3] = '{1'b0, 16'hB387, 16'h0004};
    vecs[4] = '{1'b0, 16'h670F, 16'h0008};
    vecs[5] = '{1'b1, 16'hACE1, 16'h0001};
    vecs[6] = '{1'b0, 16'h59C3, 16'h0002};
    vecs[7] = '{1'b0, 16'hB387, 16'h0004};

    #1;
    check("init16", 32'(out16), 32'h0000_ACE1);
    check("init_seed0", 32'(out0), 32'h0000_0001);
    check("init8", 32'(out8), 32'h0000_0001);

    for (int i = 0; i < 8; i++) begin
      step(vecs[i].r);
      check($sformatf("vec16[%0d]", i), 32'(out16), 32'(vecs[i].exp16));
      check($sformatf("vec_seed0[%0d]", i), 32'(out0), 32'(vecs[i].exp0));
    end

    // Wider variants: seed zero-extended, one step.
    step(1'b1);
    check("rst24", 32'(out24), 32'h0000_ACE1);
    check("rst32", out32, 32'h0000_ACE1);
    step(1'b0);
    check("step24", 32'(out24), 32'h0001_59C2);
    check("step32", out32, 32'h0001_59C3);

    // Full period at 16 bits, with the 8-bit instance's period tracked alongside.
    step(1'b1);
    rst = 1'b0;
    early16 = 0; zero16 = 0; early8 = 0; dup8 = 0; seen8 = '0;
    for (int s = 1; s <= 65535; s++) begin
      step(1'b0);
      if (out16 == 16'h0000) zero16++;
      if (out16 == 16'hACE1 && s < 65535) early16++;
      if (s <= 255) begin
        if (seen8[out8]) dup8++;
        seen8[out8] = 1'b1;
        if (out8 == 8'h01 && s < 255) early8++;
        if (s == 255) check("period8_return", 32'(out8), 32'h01);
      end
    end
    check("period16_return", 32'(out16), 32'h0000_ACE1);
    check("period16_early", early16, 0);
    check("period16_zero", zero16, 0);
    cnt8 = 0;
    for (int v = 1; v < 256; v++) if (seen8[v]) cnt8++;
    check("period8_early", early8, 0);
    check("period8_dup", dup8, 0);
    check("period8_coverage", cnt8, 255);
    check("period8_zero", 32'(seen8[0]), 32'h0);

    // Free-run then reset mid-sequence.
    for (int s = 0; s < 1000; s++) step(1'b0);
    step(1'b1);
    check("rerst", 32'(out16), 32'h0000_ACE1);
    step(1'b0);
    check("rerst_1", 32'(out16), 32'h0000_59C3);
    step(1'b0);
    check("rerst_2", 32'(out16), 32'h0000_B387);
    step(1'b0);
    check("rerst_3", 32'(out16), 32'h0000_670F);

    // Lockup guard: force the state to zero, release, and expect the seed reloaded.
    force dut16.state = 16'h0000;
    #1;
    check("forced_zero", 32'(out16), 32'h0);
    release dut16.state;
    step(1'b0);
    check("lockup_reload", 32'(out16), 32'h0000_ACE1);
    step(1'b0);
    check("lockup_next", 32'(out16), 32'h0000_59C3);

    // While reset is held, the seed is held.
    step(1'b1);
    step(1'b1);
    step(1'b1);
    check("rst_hold", 32'(out16), 32'h0000_ACE1);
    check("rst_hold_seed0", 32'(out0), 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr.md
LFSR -- requirements
Module: lfsr

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the register and output width; legal values are 8, 16, 24 and 32.
REQ-002 Parameter SEED, default 16'hACE1 (zero-extended or truncated to WIDTH), SHALL set the reset value of the state.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge of clk.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port out, output, WIDTH bits: the current LFSR state, driven directly from the state register with no combinational path from any input.

Function
REQ-006 The block SHALL be a Fibonacci LFSR: next = {state[WIDTH-2:0], fb}, where fb is the XOR of the tap bits.
REQ-007 Taps (1-based, MSB = WIDTH) SHALL give a maximal-length polynomial:
- 8: bits 8, 6, 5, 4
- 16: bits 16, 14, 13, 11, i.e. fb = s[15]^s[13]^s[12]^s[10]
- 24: bits 24, 23, 22, 17
- 32: bits 32, 22, 2, 1
REQ-008 Any other WIDTH SHALL fail elaboration with an error; silent fallback is not allowed.
REQ-009 The state SHALL advance exactly one step on every rising clk edge while rst is low; there is no enable or stall.
REQ-010 Latency: out SHALL show the new state in the cycle after the edge that computed it; out is registered.
REQ-011 Period: starting from any nonzero state, the sequence SHALL repeat after exactly 2^WIDTH-1 steps (65535 for WIDTH=16) and SHALL visit every nonzero value once per period.
REQ-012 Lockup guard: if the state is all-zero while rst is low, the next edge SHALL load the effective seed instead of shifting.
REQ-013 Effective seed SHALL be SEED, or 1 if SEED reduces to zero at WIDTH; the all-zero state SHALL never persist for more than one cycle.
REQ-014 The all-ones state is a legal state and SHALL shift normally.
REQ-015 The output SHALL be usable as a memory-mapped random word; consumers may sample it on any cycle.
REQ-016 Successive samples are not required to be independent.

Reset
REQ-017 When rst is high at a rising clk edge, the state SHALL load the effective seed on that edge; out = 16'hACE1 for the default parameters.
REQ-018 rst SHALL take priority over shifting and over the lockup guard.
REQ-019 Reset asserted mid-sequence SHALL discard the current state; the sequence then restarts from the seed exactly as after power-up.
REQ-020 While rst stays high, out SHALL hold the seed.
REQ-021 The first shift SHALL occur on the first rising edge with rst low.
REQ-022 For simulation, the initial value of the state register SHALL be the effective seed.

Verification
REQ-023 Defaults, rst high for 2 cycles -> out = 16'hACE1; after the 1st, 2nd and 3rd edges with rst low -> 16'h59C3, 16'hB387, 16'h670F.
REQ-024 Defaults, run 65535 edges from reset -> out returns to 16'hACE1 and has not equalled 16'hACE1 at any earlier step; the value 16'h0000 never appears.
REQ-025 Defaults, reset again after 1000 free-running cycles -> out = 16'hACE1 on the next edge; the next three values repeat 59C3, B387, 670F.
REQ-026 Force the state to 0 (WIDTH=16) -> the next edge gives 16'hACE1.
REQ-027 Instantiate with SEED=0 -> after reset out = 16'h0001; after one edge out = 16'h0002.
REQ-028 WIDTH=8, SEED=8'h01 -> the period is exactly 255 steps and every value 1..255 appears once.
